fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and drives the icache request (imemREN, imemaddr).
- Holds one fetched word in a 1-entry skid buffer while the pipeline stalls.
- Owns the IF/ID latch, which is gated by the hazard unit's FDen/FDflush and redirected by pc_src.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, PC/address width; instruction word fixed at 32 bits.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
ihit  in  1  icache returns imemload for imemaddr this cycle.
imemload  in  32  instruction word from icache.
imemREN  out  1  instruction read request.
imemaddr  out  ADDR_W  fetch address (= PC).
FDen  in  1  IF/ID latch enable (hazard unit).
FDflush  in  1  IF/ID latch flush (hazard unit).
pc_src  in  2  00 sequential, 01 branch_target, 10 jump_target, 11 jr_target.
branch_target  in  ADDR_W  resolved branch address.
jump_target  in  ADDR_W  J/JAL address.
jr_target  in  ADDR_W  JR register value.
halt  in  1  HALT committed downstream.
fd_instr  out  32  IF/ID instruction.
fd_pc  out  ADDR_W  IF/ID PC of instruction.
fd_npc  out  ADDR_W  IF/ID PC+4.
fd_valid  out  1  IF/ID holds a real instruction.
halted  out  1  fetch frozen.

Behaviour:
- Reset (RST high, async):
  - pc = PC_INIT, state = RUN, buf_valid = 0, buf_instr = 0.
  - fd_instr = 0, fd_pc = 0, fd_npc = 0, fd_valid = 0, halted = 0.
  - imemREN forced to 0 while RST is high.
  - Reset mid-stall or mid-redirect discards everything.
- States:
  - RUN -> HALTED on any edge with halt = 1.
  - HALTED is sticky; only RST exits it.
  - In HALTED: imemREN = 0, pc/buffer/IF/ID frozen (FDflush still honoured), halted = 1.
- Combinational outputs:
  - imemaddr = pc.
  - imemREN = (state == RUN) && !buf_valid && !RST.
- word_avail = buf_valid || (ihit && imemREN). word = buf_valid ? buf_instr : imemload.
- Redirect: any cycle in RUN with pc_src != 00.
  - pc <= selected target at the edge, regardless of ihit/FDen.
  - buf_valid <= 0; the in-flight word is discarded.
  - IF/ID does not capture the word: it loads a bubble if FDen, else holds.
  - A level held over multiple stall cycles is idempotent.
  - pc_src has priority over sequential advance.
- Sequential advance (RUN, pc_src == 00):
  - FDen && word_avail:
    - IF/ID <= {word, pc, pc+4, valid = 1}.
    - pc <= pc+4; buf_valid <= 0.
  - !FDen && ihit && imemREN:
    - buf_instr <= imemload, buf_valid <= 1.
    - pc unchanged (PC advances only on consume).
  - FDen && !word_avail: IF/ID <= bubble (instr 0, valid 0, pc/npc 0); pc unchanged.
  - !FDen otherwise: IF/ID and pc hold.
- FDflush has priority over FDen for the IF/ID latch:
  - Latch <= bubble.
  - A word available this cycle is not consumed, so pc does not advance on it.
  - A redirect in the same cycle still updates pc.
- Priority order: RST > HALTED > FDflush (latch) / pc_src (pc) > FDen > hold.
- pc+4 wraps modulo 2^ADDR_W; bits [1:0] are not checked.
- Latency: word fetched at edge N appears on fd_* after edge N when FDen; zero added cycles with ihit each cycle.

Test Plan:
- Streaming: reset, PC_INIT = 0, ihit = 1 every cycle, FDen = 1 -> fd_pc 0,4,8,12 on consecutive edges, fd_valid = 1, imemREN = 1.
- Stall skid:
  - Cycle 0: ihit = 1, FDen = 0, imemload = 0xAAAA0001 at pc 0x10 -> buf_valid = 1, imemREN = 0, pc stays 0x10.
  - Two cycles later, FDen = 1 -> fd_instr = 0xAAAA0001, fd_pc = 0x10, next imemaddr = 0x14.
- Redirect:
  - pc = 0x40, pc_src = 01, branch_target = 0x100, ihit = 1, FDen = 1 -> pc = 0x100, fd_valid = 0.
  - Next word fetched from 0x100.
  - Repeat with pc_src = 10 (jump_target) and pc_src = 11 (jr_target).
- Flush vs stall: buf_valid = 1 with FDflush = 1, FDen = 0 -> fd_valid = 0, buffer retained, pc unchanged. Flush plus redirect -> buffer cleared, pc = target.
- Halt:
  - halt = 1 for one cycle at pc = 0x20 -> halted = 1, imemREN = 0, pc stays 0x20 for 10 cycles despite pc_src/ihit.
  - RST -> pc = PC_INIT, halted = 0.
- Async reset mid-skid: assert RST between clock edges while buf_valid = 1 -> immediately buf_valid = 0, fd_valid = 0, imemREN = 0, pc = PC_INIT.
- Wrap: PC_INIT = 32'hFFFF_FFFC, ihit = 1, FDen = 1 -> fd_npc = 0, next imemaddr = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch for the 5-stage MIPS pipeline: owns the PC, the icache request, a 1-word skid buffer and the IF/ID latch.
// Latency: a word fetched at edge N appears on fd_* after edge N when FDen is high; no added cycles while ihit is high every cycle.
// Backpressure: with FDen low, a hit word is parked in the skid buffer and imemREN drops until the word is consumed or a redirect discards it.
module fetch_stage #(
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [31:0]       imemload,
    output logic              imemREN,
    output logic [ADDR_W-1:0] imemaddr,
    input  logic              FDen,
    input  logic              FDflush,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              halt,
    output logic [31:0]       fd_instr,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [ADDR_W-1:0] fd_npc,
    output logic              fd_valid,
    output logic              halted
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_plus4, redirect_pc;
    logic              buf_valid, buf_valid_nxt;
    logic [31:0]       buf_instr, buf_instr_nxt;
    logic [31:0]       fd_instr_nxt;
    logic [ADDR_W-1:0] fd_pc_nxt, fd_npc_nxt;
    logic              fd_valid_nxt;
    logic              run, redirect, word_avail, consume, capture;
    logic [31:0]       word;

    assign imemaddr   = pc;
    assign imemREN    = (state == RUN) && !buf_valid && !RST;
    assign halted     = (state == HALTED);
    assign pc_plus4   = pc + PC_STEP;
    assign word_avail = buf_valid || (ihit && imemREN);
    assign word       = buf_valid ? buf_instr : imemload;

    // A halt arriving this edge freezes fetch immediately, same as being in HALTED.
    assign run      = (state == RUN) && !halt;
    assign redirect = run && (pc_src != 2'b00);
    assign consume  = run && !redirect && FDen && !FDflush && word_avail;
    assign capture  = run && !redirect && !consume && ihit && imemREN;

    always_comb begin
        case (pc_src)
            2'b01:   redirect_pc = branch_target;
            2'b10:   redirect_pc = jump_target;
            2'b11:   redirect_pc = jr_target;
            default: redirect_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        buf_valid_nxt = buf_valid;
        buf_instr_nxt = buf_instr;
        fd_instr_nxt  = fd_instr;
        fd_pc_nxt     = fd_pc;
        fd_npc_nxt    = fd_npc;
        fd_valid_nxt  = fd_valid;

        if (state == RUN && halt) begin
            state_nxt = HALTED;
        end

        if (redirect) begin
            pc_nxt = redirect_pc;
        end else if (consume) begin
            pc_nxt = pc_plus4;
        end

        if (redirect || consume) begin
            buf_valid_nxt = 1'b0;
        end else if (capture) begin
            buf_valid_nxt = 1'b1;
            buf_instr_nxt = imemload;
        end

        // Flush beats everything for the latch, even while halted.
        if (FDflush || (run && FDen && !consume)) begin
            fd_instr_nxt = '0;
            fd_pc_nxt    = '0;
            fd_npc_nxt   = '0;
            fd_valid_nxt = 1'b0;
        end else if (consume) begin
            fd_instr_nxt = word;
            fd_pc_nxt    = pc;
            fd_npc_nxt   = pc_plus4;
            fd_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            pc        <= PC_INIT;
            buf_valid <= 1'b0;
            buf_instr <= '0;
            fd_instr  <= '0;
            fd_pc     <= '0;
            fd_npc    <= '0;
            fd_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            buf_valid <= buf_valid_nxt;
            buf_instr <= buf_instr_nxt;
            fd_instr  <= fd_instr_nxt;
            fd_pc     <= fd_pc_nxt;
            fd_npc    <= fd_npc_nxt;
            fd_valid  <= fd_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, directed corner sequences, randomized run against a queue-based model.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, FDen, FDflush, halt;
    logic [31:0] imemload, branch_target, jump_target, jr_target;
    logic [1:0]  pc_src;

    logic        a_ren, a_valid, a_halted;
    logic [31:0] a_addr, a_instr, a_pc, a_npc;
    logic        b_ren, b_valid, b_halted;
    logic [31:0] b_addr, b_instr, b_pc, b_npc;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(.ADDR_W(32), .PC_INIT(32'h0000_0000)) dut_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(a_ren), .imemaddr(a_addr), .FDen(FDen), .FDflush(FDflush),
        .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
        .jr_target(jr_target), .halt(halt), .fd_instr(a_instr), .fd_pc(a_pc),
        .fd_npc(a_npc), .fd_valid(a_valid), .halted(a_halted)
    );

    fetch_stage #(.ADDR_W(32), .PC_INIT(32'hFFFF_FFFC)) dut_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(b_ren), .imemaddr(b_addr), .FDen(FDen), .FDflush(FDflush),
        .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
        .jr_target(jr_target), .halt(halt), .fd_instr(b_instr), .fd_pc(b_pc),
        .fd_npc(b_npc), .fd_valid(b_valid), .halted(b_halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ih, input logic fe, input logic fl,
                         input logic [1:0] src, input logic [31:0] load);
        ihit = ih; FDen = fe; FDflush = fl; pc_src = src; imemload = load;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        halt = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Reference model: PC, a queue holding the parked word, and the IF/ID record.
    logic [31:0] m_pc, m_instr, m_fpc, m_npc;
    logic        m_valid;
    logic [31:0] m_skid[$];

    task automatic model_reset();
        m_pc = 32'h0; m_skid.delete();
        m_instr = 0; m_fpc = 0; m_npc = 0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic        ren, avail, take;
        logic [31:0] w, tgt;
        ren   = (m_skid.size() == 0);
        avail = !ren || ihit;
        w     = ren ? imemload : m_skid[0];
        tgt   = (pc_src == 2'b01) ? branch_target :
                (pc_src == 2'b10) ? jump_target : jr_target;
        take  = (pc_src == 2'b00) && FDen && !FDflush && avail;
        if (take) begin
            m_instr = w; m_fpc = m_pc; m_npc = m_pc + 32'd4; m_valid = 1'b1;
        end else if (FDflush || FDen) begin
            m_instr = 0; m_fpc = 0; m_npc = 0; m_valid = 1'b0;
        end
        if (pc_src != 2'b00) begin
            m_pc = tgt;
            m_skid.delete();
        end else if (take) begin
            m_pc = m_pc + 32'd4;
            m_skid.delete();
        end else if (ihit && ren) begin
            m_skid.push_back(imemload);
        end
    endtask

    typedef struct {
        logic        ih, fe, fl;
        logic [31:0] load;
        logic        e_valid;
        logic [31:0] e_pc, e_instr, e_addr;
        logic        e_ren;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] tg;

        vecs[0]  = '{1, 1, 0, 32'h1111_1111, 1, 32'h00, 32'h1111_1111, 32'h04, 1};
        vecs[1]  = '{1, 1, 0, 32'h2222_2222, 1, 32'h04, 32'h2222_2222, 32'h08, 1};
        vecs[2]  = '{1, 1, 0, 32'h3333_3333, 1, 32'h08, 32'h3333_3333, 32'h0C, 1};
        vecs[3]  = '{1, 1, 0, 32'h4444_4444, 1, 32'h0C, 32'h4444_4444, 32'h10, 1};
        vecs[4]  = '{1, 0, 0, 32'hAAAA_0001, 1, 32'h0C, 32'h4444_4444, 32'h10, 0};
        vecs[5]  = '{1, 0, 0, 32'hDEAD_BEEF, 1, 32'h0C, 32'h4444_4444, 32'h10, 0};
        vecs[6]  = '{0, 0, 0, 32'hDEAD_BEEF, 1, 32'h0C, 32'h4444_4444, 32'h10, 0};
        vecs[7]  = '{0, 1, 0, 32'hDEAD_BEEF, 1, 32'h10, 32'hAAAA_0001, 32'h14, 1};
        vecs[8]  = '{0, 1, 0, 32'hDEAD_BEEF, 0, 32'h00, 32'h0000_0000, 32'h14, 1};
        vecs[9]  = '{1, 0, 1, 32'hBBBB_0002, 0, 32'h00, 32'h0000_0000, 32'h14, 0};
        vecs[10] = '{0, 0, 1, 32'hDEAD_BEEF, 0, 32'h00, 32'h0000_0000, 32'h14, 0};
        vecs[11] = '{0, 1, 0, 32'hDEAD_BEEF, 1, 32'h14, 32'hBBBB_0002, 32'h18, 1};

        branch_target = 0; jump_target = 0; jr_target = 0; halt = 1'b0;
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        #1;
        chk("rst_fd_valid", a_valid, 0);
        chk("rst_fd_instr", a_instr, 0);
        chk("rst_fd_pc", a_pc, 0);
        chk("rst_fd_npc", a_npc, 0);
        chk("rst_halted", a_halted, 0);
        chk("rst_imemaddr", a_addr, 32'h0);
        chk("rst_imemren_low", a_ren, 0);
        chk("rst_b_imemaddr", b_addr, 32'hFFFF_FFFC);
        tick();
        RST = 1'b0;
        #1;
        chk("post_rst_imemren", a_ren, 1);

        // PC wraps modulo 2^32
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h1234_5678);
        tick();
        chk("wrap_fd_pc", b_pc, 32'hFFFF_FFFC);
        chk("wrap_fd_npc", b_npc, 32'h0);
        chk("wrap_imemaddr", b_addr, 32'h0);
        chk("wrap_fd_instr", b_instr, 32'h1234_5678);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ih, vecs[i].fe, vecs[i].fl, 2'b00, vecs[i].load);
            tick();
            chk($sformatf("vec%0d_valid", i), a_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_pc", i), a_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_npc", i), a_npc, vecs[i].e_valid ? vecs[i].e_pc + 32'd4 : 32'h0);
            chk($sformatf("vec%0d_instr", i), a_instr, vecs[i].e_instr);
            chk($sformatf("vec%0d_addr", i), a_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_ren", i), a_ren, vecs[i].e_ren);
        end

        // Redirect through each pc_src source from pc 0x40
        for (int k = 1; k <= 3; k++) begin
            branch_target = 32'h40;
            drive(1'b0, 1'b0, 1'b0, 2'b01, 32'h0);
            tick();
            chk("redir_setup_addr", a_addr, 32'h40);
            branch_target = 32'h100; jump_target = 32'h200; jr_target = 32'h300;
            tg = (k == 1) ? 32'h100 : (k == 2) ? 32'h200 : 32'h300;
            drive(1'b1, 1'b1, 1'b0, 2'(k), 32'h0BAD_0BAD);
            tick();
            chk($sformatf("redir%0d_addr", k), a_addr, tg);
            chk($sformatf("redir%0d_fd_valid", k), a_valid, 0);
            drive(1'b1, 1'b1, 1'b0, 2'b00, 32'hC0DE_0000 | k);
            tick();
            chk($sformatf("redir%0d_next_pc", k), a_pc, tg);
            chk($sformatf("redir%0d_next_instr", k), a_instr, 32'hC0DE_0000 | k);
            chk($sformatf("redir%0d_next_addr", k), a_addr, tg + 32'd4);
        end

        // Redirect level held across stall cycles is idempotent
        branch_target = 32'h600;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h0BAD_0BAD);
            tick();
            chk("hold_redir_addr", a_addr, 32'h600);
            chk("hold_redir_ren", a_ren, 1);
        end

        // Flush plus redirect clears a parked word
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h7777_0007);
        tick();
        chk("park_ren", a_ren, 0);
        jump_target = 32'h500;
        drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0);
        tick();
        chk("flush_redir_valid", a_valid, 0);
        chk("flush_redir_addr", a_addr, 32'h500);
        chk("flush_redir_ren", a_ren, 1);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h5555_0005);
        tick();
        chk("flush_redir_instr", a_instr, 32'h5555_0005);
        chk("flush_redir_pc", a_pc, 32'h500);

        // Halt freezes fetch until reset
        branch_target = 32'h20;
        drive(1'b0, 1'b0, 1'b0, 2'b01, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_halted", a_halted, 1);
        chk("halt_ren", a_ren, 0);
        chk("halt_addr", a_addr, 32'h20);
        for (int i = 0; i < 10; i++) begin
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_target   = $urandom & 32'hFFFF_FFFC;
            jr_target     = $urandom & 32'hFFFF_FFFC;
            drive(1'b1, 1'b1, 1'b0, 2'($urandom_range(1, 3)), $urandom);
            tick();
            chk("halted_addr", a_addr, 32'h20);
            chk("halted_ren", a_ren, 0);
            chk("halted_flag", a_halted, 1);
        end
        #2;
        RST = 1'b1;
        #1;
        chk("halt_rst_addr", a_addr, 32'h0);
        chk("halt_rst_halted", a_halted, 0);
        tick();
        RST = 1'b0;

        // Async reset while a word is parked
        drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0001);
        tick();
        chk("skidrst_pre_valid", a_valid, 1);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0002);
        tick();
        chk("skidrst_pre_ren", a_ren, 0);
        #2;
        RST = 1'b1;
        #1;
        chk("skidrst_ren", a_ren, 0);
        chk("skidrst_valid", a_valid, 0);
        chk("skidrst_addr", a_addr, 32'h0);
        chk("skidrst_instr", a_instr, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        tick();
        RST = 1'b0;
        #1;
        chk("skidrst_buf_cleared", a_ren, 1);

        // Randomized run against the model
        model_reset();
        for (int i = 0; i < 600; i++) begin
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_target   = $urandom & 32'hFFFF_FFFC;
            jr_target     = $urandom & 32'hFFFF_FFFC;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  $urandom);
            model_step();
            tick();
            chk("rand_valid", a_valid, m_valid);
            chk("rand_instr", a_instr, m_instr);
            chk("rand_pc", a_pc, m_fpc);
            chk("rand_npc", a_npc, m_npc);
            chk("rand_addr", a_addr, m_pc);
            chk("rand_ren", a_ren, m_skid.size() == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
